div_issue_unit: RTL
===================

Name: div_issue_unit

Overview:
Front-end and result buffer for the iterative divider (`div`) in the integer divide pipe.
- Accepts one M-extension divide/remainder op from the issue stage over a valid/ready handshake and registers its operands.
- Launches the divider with a single-cycle start pulse, captures quotient or remainder on `div_finish`, and holds the result until the writeback/CDB arbiter takes it.
- Handles pipeline flush, including a flush that lands while the divider is mid-operation.

Parameters:
TAG_WIDTH, 6, ROB tag width carried with the op.
RD_WIDTH, 5, destination register index width.

Ports:
clk  in  1  clock
rst_n  in  1  reset
issue_valid  in  1  op offered by issue stage
issue_ready  out  1  unit can accept op this cycle
issue_op  in  3  `DIV_OP_DIV / `DIV_OP_DIVU / `DIV_OP_REM / `DIV_OP_REMU
issue_rs1_data  in  `WORD_WIDTH  dividend
issue_rs2_data  in  `WORD_WIDTH  divisor
issue_tag  in  TAG_WIDTH  ROB tag
issue_rd  in  RD_WIDTH  destination register
flush  in  1  kill all in-flight work
div_start  out  1  start pulse to divider
div_opcode  out  3  `DIV_OP_DIV (signed) or `DIV_OP_DIVU (unsigned)
div_divident  out  `WORD_WIDTH  dividend to divider
div_divisor  out  `WORD_WIDTH  divisor to divider
div_quotient  in  `WORD_WIDTH  divider quotient, valid while div_finish=1
div_remainder  in  `WORD_WIDTH  divider remainder, valid while div_finish=1
div_finish  in  1  divider completion pulse
wb_valid  out  1  result available
wb_ready  in  1  arbiter accepts result
wb_tag  out  TAG_WIDTH  result ROB tag
wb_rd  out  RD_WIDTH  result destination
wb_data  out  `WORD_WIDTH  result value

Behaviour:
- Clock and reset: one clock `clk`. `rst_n` is asynchronous, active-low.
- Reset state: IDLE. All outputs are 0 except `issue_ready`, which is 1 once `rst_n` deasserts (combinational from state). Operand, tag, op and result registers are all 0.
- States:
  - IDLE: waiting for an op.
  - START: `div_start` driven.
  - BUSY: waiting for `div_finish`.
  - DONE: `wb_valid`=1, result held.
  - DRAIN: flushed op still in the divider.
- `issue_ready` = !flush && (IDLE || (DONE && wb_ready)).
- Accept = issue_valid && issue_ready. On accept:
  - Register rs1, rs2, tag, rd and op.
  - Set a rem flag = (op is REM or REMU).
  - Divider opcode = DIV for DIV/REM, DIVU for DIVU/REMU.
  - Next state START.
- START (exactly one cycle):
  - `div_start`=1, with `div_opcode`/`div_divident`/`div_divisor` driven from the registered values.
  - `div_finish` in the same cycle (divide-by-zero or overflow, which the divider completes combinationally): capture result, go to DONE.
  - Otherwise go to BUSY.
- BUSY: on `div_finish`, capture result, go to DONE.
- Result capture: `wb_data` = rem flag ? div_remainder : div_quotient. It is registered, so `wb_valid` rises the cycle after `div_finish`.
- Unsupported `issue_op`: the op is accepted and no `div_start` is issued. START goes directly to DONE with `wb_data`=0.
- DONE:
  - `wb_valid`=1. `wb_tag`/`wb_rd`/`wb_data` stay stable while `wb_ready`=0.
  - On `wb_ready`: go to START if a new op is accepted the same cycle (back-to-back), else IDLE.
  - `wb_valid` drops only when the state leaves DONE.
- Divider operand outputs hold their last values outside START. `div_start` is 1 only in START.
- Latency: accept at cycle T, `div_start` at T+1, `wb_valid` at F+1 where F is the `div_finish` cycle. For a single-cycle divider completion, `wb_valid` is at T+2.
- Flush (priority over everything else):
  - IDLE: no accept.
  - START: suppress `div_start`, go to IDLE.
  - BUSY: go to DRAIN. The divider cannot be cancelled.
  - DONE: drop the result; `wb_valid`=0 next cycle; go to IDLE.
  - DRAIN: stay.
- DRAIN: `issue_ready`=0. On `div_finish`, discard the result and go to IDLE. No `wb_valid` is ever produced for a flushed op.
- A `div_finish` arriving in IDLE or DONE is ignored. It is a protocol error and is asserted against in the bench.
- Reset mid-operation: immediately return to IDLE with all outputs cleared. The divider is reset by the same `rst_n`.
- At most one op is in flight. There is no queue.

Test Plan:
- DIVU 100/7 issued at T -> `div_start`=1 at T+1 with div_opcode=`DIV_OP_DIVU`, rs1=100, rs2=7; `wb_valid` the cycle after `div_finish`, `wb_data`=14. REMU 100/7 -> `wb_data`=2.
- DIV 0xFFFFFFF9 / 2 -> `wb_data`=0xFFFFFFFD. REM of the same operands -> `wb_data`=0xFFFFFFFF. Both drive div_opcode=`DIV_OP_DIV`.
- DIVU 5/0 at T -> `div_finish` during START, `wb_valid` at T+2, `wb_data`=0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Hold `wb_ready`=0 for 3 cycles in DONE:
  - `wb_valid`, `wb_data` and `wb_tag` stay stable; `issue_ready`=0.
  - Then raise `wb_ready` while presenting a new op: it is accepted in the same cycle, and `div_start` fires next cycle.
- Flush 3 cycles after `div_start` on a long DIVU (0xFFFFFFFF/3) -> state DRAIN, `issue_ready`=0 until the cycle after `div_finish`, no `wb_valid` for that tag. A following DIVU 9/3 returns 3.
- Flush during START -> no `div_start` pulse, IDLE next cycle. Assert `rst_n` while in BUSY -> all outputs 0 asynchronously; the next op completes correctly.

Source files
------------

// File: rtl/div_issue_unit_if.sv
// Issue, divider and writeback signals of the divide issue unit.
// The slave modport is the unit itself; the master modport is its environment.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV 3'b100
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 3'b101
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM 3'b110
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 3'b111
`endif

interface div_issue_unit_if #(
    parameter int TAG_WIDTH = 6,
    parameter int RD_WIDTH  = 5
);
    logic                   issue_valid;
    logic                   issue_ready;
    logic [2:0]             issue_op;
    logic [`WORD_WIDTH-1:0] issue_rs1_data;
    logic [`WORD_WIDTH-1:0] issue_rs2_data;
    logic [TAG_WIDTH-1:0]   issue_tag;
    logic [RD_WIDTH-1:0]    issue_rd;
    logic                   flush;
    logic                   div_start;
    logic [2:0]             div_opcode;
    logic [`WORD_WIDTH-1:0] div_divident;
    logic [`WORD_WIDTH-1:0] div_divisor;
    logic [`WORD_WIDTH-1:0] div_quotient;
    logic [`WORD_WIDTH-1:0] div_remainder;
    logic                   div_finish;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [TAG_WIDTH-1:0]   wb_tag;
    logic [RD_WIDTH-1:0]    wb_rd;
    logic [`WORD_WIDTH-1:0] wb_data;

    modport slave (
        input  issue_valid, issue_op, issue_rs1_data, issue_rs2_data, issue_tag, issue_rd,
        input  flush, div_quotient, div_remainder, div_finish, wb_ready,
        output issue_ready, div_start, div_opcode, div_divident, div_divisor,
        output wb_valid, wb_tag, wb_rd, wb_data
    );

    modport master (
        output issue_valid, issue_op, issue_rs1_data, issue_rs2_data, issue_tag, issue_rd,
        output flush, div_quotient, div_remainder, div_finish, wb_ready,
        input  issue_ready, div_start, div_opcode, div_divident, div_divisor,
        input  wb_valid, wb_tag, wb_rd, wb_data
    );
endinterface

// File: rtl/div_issue_unit.sv
// Front-end and result buffer for the iterative divider: accepts one op,
// pulses the divider start, and holds the quotient/remainder for writeback.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV 3'b100
`endif
`ifndef DIV_OP_DIVU
`define DIV_OP_DIVU 3'b101
`endif
`ifndef DIV_OP_REM
`define DIV_OP_REM 3'b110
`endif
`ifndef DIV_OP_REMU
`define DIV_OP_REMU 3'b111
`endif

module div_issue_unit #(
    parameter int TAG_WIDTH = 6,
    parameter int RD_WIDTH  = 5
) (
    input logic             clk,
    input logic             rst_n,
    div_issue_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [`WORD_WIDTH-1:0] rs1_q, rs1_d;
    logic [`WORD_WIDTH-1:0] rs2_q, rs2_d;
    logic [`WORD_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [RD_WIDTH-1:0]    rd_q, rd_d;
    logic [2:0]             opcode_q, opcode_d;
    logic                   rem_q, rem_d;
    logic                   supported_q, supported_d;

    logic                   issue_ready;
    logic                   accept;
    logic                   op_rem;
    logic                   op_unsigned;
    logic                   op_supported;
    logic [`WORD_WIDTH-1:0] div_result;

    always_comb begin
        op_rem       = (bus.issue_op == `DIV_OP_REM)  || (bus.issue_op == `DIV_OP_REMU);
        op_unsigned  = (bus.issue_op == `DIV_OP_DIVU) || (bus.issue_op == `DIV_OP_REMU);
        op_supported = (bus.issue_op == `DIV_OP_DIV)  || (bus.issue_op == `DIV_OP_DIVU) || op_rem;
    end

    // Ready is held low during reset so nothing is offered before the unit is live.
    assign issue_ready = rst_n && !bus.flush &&
                         ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.wb_ready));
    assign accept      = bus.issue_valid && issue_ready;
    assign div_result  = rem_q ? bus.div_remainder : bus.div_quotient;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        wb_data_d   = wb_data_q;
        tag_d       = tag_q;
        rd_d        = rd_q;
        opcode_d    = opcode_q;
        rem_d       = rem_q;
        supported_d = supported_q;

        if (accept) begin
            rs1_d       = bus.issue_rs1_data;
            rs2_d       = bus.issue_rs2_data;
            tag_d       = bus.issue_tag;
            rd_d        = bus.issue_rd;
            rem_d       = op_rem;
            supported_d = op_supported;
            opcode_d    = op_unsigned ? `DIV_OP_DIVU : `DIV_OP_DIV;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_START;
            end
            S_START: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (!supported_q) begin
                    wb_data_d = '0;
                    state_d   = S_DONE;
                end else if (bus.div_finish) begin
                    wb_data_d = div_result;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    state_d = S_DRAIN;
                end else if (bus.div_finish) begin
                    wb_data_d = div_result;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.flush)         state_d = S_IDLE;
                else if (bus.wb_ready) state_d = accept ? S_START : S_IDLE;
            end
            S_DRAIN: begin
                // The divider cannot be cancelled; its completion is the only way out.
                if (bus.div_finish) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            wb_data_q   <= '0;
            tag_q       <= '0;
            rd_q        <= '0;
            opcode_q    <= '0;
            rem_q       <= 1'b0;
            supported_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            wb_data_q   <= wb_data_d;
            tag_q       <= tag_d;
            rd_q        <= rd_d;
            opcode_q    <= opcode_d;
            rem_q       <= rem_d;
            supported_q <= supported_d;
        end
    end

    assign bus.issue_ready  = issue_ready;
    assign bus.div_start    = (state_q == S_START) && supported_q && !bus.flush;
    assign bus.div_opcode   = opcode_q;
    assign bus.div_divident = rs1_q;
    assign bus.div_divisor  = rs2_q;
    assign bus.wb_valid     = (state_q == S_DONE);
    assign bus.wb_tag       = tag_q;
    assign bus.wb_rd        = rd_q;
    assign bus.wb_data      = wb_data_q;
endmodule
